// File: rtl/nios2_bus_cmd_decoder.sv
// Nios II bus-output PIO command decoder: each toggle of bus_in[7] queues
// bus_in[6:0] into a show-ahead FIFO drained over a valid/ready handshake.
//
// Ports:
//   clk        in   system clock, same domain as the PIO
//   reset_n    in   synchronous active-low reset
//   bus_in     in   PIO out_port; [7] toggle flag, [6:0] command
//   cmd_data   out  FIFO head command (0 while empty)
//   cmd_valid  out  FIFO non-empty
//   cmd_ready  in   consumer accepts the head while cmd_valid is high
//   ack_toggle out  toggle flag of the last accepted command
//   pending    out  a toggle is waiting because the FIFO is full
//   fill_level out  current FIFO occupancy
module nios2_bus_cmd_decoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int CMD_WIDTH  = 7
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [CMD_WIDTH:0]            bus_in,
    output logic [CMD_WIDTH-1:0]          cmd_data,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic                          ack_toggle,
    output logic                          pending,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [CMD_WIDTH:0]   bus_q;
    logic                 last_toggle_q;
    logic                 ack_q;
    logic                 pending_q;
    logic                 pending_d;
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q;
    logic [AW-1:0]        rd_ptr_d;
    logic [AW:0]          count_q;
    logic [AW:0]          count_d;
    logic [CMD_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic ev;
    logic full;
    logic empty;
    logic push;
    logic pop;

    // Push eligibility uses the count at the start of the cycle, so a
    // pop on a full FIFO frees the slot only for the following cycle.
    always_comb begin
        ev    = bus_q[CMD_WIDTH] != last_toggle_q;
        full  = count_q == CNT_FULL;
        empty = count_q == '0;
        push  = ev && !full;
        pop   = !empty && cmd_ready;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        pending_d = ev && full;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push && pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus_q         <= '0;
            last_toggle_q <= 1'b0;
            ack_q         <= 1'b0;
            pending_q     <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            bus_q     <= bus_in;
            pending_q <= pending_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            if (push) begin
                last_toggle_q <= bus_q[CMD_WIDTH];
                ack_q         <= bus_q[CMD_WIDTH];
            end
        end
    end

    // Storage needs no reset; the output mux hides stale entries.
    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            mem_q[wr_ptr_q] <= bus_q[CMD_WIDTH-1:0];
        end
    end

    always_comb begin
        cmd_valid  = !empty;
        cmd_data   = empty ? '0 : mem_q[rd_ptr_q];
        ack_toggle = ack_q;
        pending    = pending_q;
        fill_level = count_q;
    end

endmodule
